// File: rtl/sd_text_pkg.sv
// Shared types and helpers for the SD text word scanner.
package sd_text_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_COUNT,
        ST_DONE
    } state_e;

    localparam logic [7:0] CHAR_LF = 8'h0A;

    function automatic logic is_word_char(
        input logic [7:0] c,
        input logic       alnum
    );
        return (c >= 8'h41 && c <= 8'h5A) ||
               (c >= 8'h61 && c <= 8'h7A) ||
               (c == 8'h5F) ||
               (alnum && c >= 8'h30 && c <= 8'h39);
    endfunction

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic [31:0] max
    );
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/sd_tag_matcher.sv
// Streaming tag matcher; pulses match_o on the byte completing the tag.
module sd_tag_matcher
#(
    parameter int                   TAG_LEN = 9,
    parameter logic [TAG_LEN*8-1:0] TAG     = '0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] byte_i,
    output logic       match_o
);

    localparam int IW = $clog2(TAG_LEN);
    localparam logic [IW-1:0] LAST = IW'(TAG_LEN - 1);
    localparam logic [7:0] FIRST = TAG[TAG_LEN*8-1 -: 8];

    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic [7:0]    cur;
    logic          hit;

    assign cur     = TAG[(TAG_LEN - 1 - int'(idx_q))*8 +: 8];
    assign hit     = (byte_i == cur);
    assign match_o = en && hit && (idx_q == LAST);

    // A failed byte may itself be the start of a new tag.
    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (en) begin
            if (match_o)               idx_d = '0;
            else if (hit)              idx_d = idx_q + 1'b1;
            else if (byte_i == FIRST)  idx_d = IW'(1);
            else                       idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) idx_q <= '0;
        else          idx_q <= idx_d;
    end

endmodule

// File: rtl/sd_text_word_scanner.sv
// Scans tag-delimited text on the SD data path, counting words of a
// selected length and keeping a saturating word-length histogram.
module sd_text_word_scanner
    import sd_text_pkg::*;
#(
    parameter int                   TAG_LEN   = 9,
    parameter logic [TAG_LEN*8-1:0] BEGIN_TAG = {"DLAB_TAG", CHAR_LF},
    parameter logic [TAG_LEN*8-1:0] END_TAG   = {"DLAB_END", CHAR_LF},
    parameter int                   LEN_W     = 8,
    parameter int                   CNT_W     = 16,
    parameter int                   NUM_BINS  = 4,
    parameter bit                   ALNUM     = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [LEN_W-1:0]          target_len,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic                      busy,
    output logic                      in_text,
    output logic                      done,
    output logic [CNT_W-1:0]          word_count,
    output logic [NUM_BINS*CNT_W-1:0] hist_flat,
    output logic [31:0]               byte_count
);

    localparam int BW = $clog2(NUM_BINS);
    localparam logic [31:0] LEN_MAX = 32'({LEN_W{1'b1}});
    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    state_e           state_q;
    logic [LEN_W-1:0] target_q;
    logic [LEN_W-1:0] wlen_q;
    logic [CNT_W-1:0] wc_q;
    logic [CNT_W-1:0] hist_q [NUM_BINS];
    logic [31:0]      bc_q;

    logic             accept;
    logic             clr;
    logic             beg_match;
    logic             end_match;
    logic             word_ch;
    logic             hit_d;
    logic [LEN_W-1:0] wlen_d;
    logic [CNT_W-1:0] wc_d;
    logic [31:0]      bc_d;
    logic [BW-1:0]    bin_d;
    logic [CNT_W-1:0] bin_inc_d;

    assign busy     = (state_q == ST_SEARCH) || (state_q == ST_COUNT);
    assign in_ready = busy;
    assign in_text  = (state_q == ST_COUNT);
    assign done     = (state_q == ST_DONE);

    // abort outranks a byte offered in the same cycle
    assign accept = in_valid && busy && !abort;
    assign clr    = start && !busy;

    sd_tag_matcher #(
        .TAG_LEN (TAG_LEN),
        .TAG     (BEGIN_TAG)
    ) u_begin (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .en      (accept && state_q == ST_SEARCH),
        .byte_i  (in_data),
        .match_o (beg_match)
    );

    sd_tag_matcher #(
        .TAG_LEN (TAG_LEN),
        .TAG     (END_TAG)
    ) u_end (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .en      (accept && state_q == ST_COUNT),
        .byte_i  (in_data),
        .match_o (end_match)
    );

    always_comb begin
        word_ch   = is_word_char(in_data, ALNUM);
        wlen_d    = LEN_W'(sat_inc(32'(wlen_q), LEN_MAX));
        wc_d      = CNT_W'(sat_inc(32'(wc_q), CNT_MAX));
        bc_d      = sat_inc(bc_q, 32'hFFFF_FFFF);
        hit_d     = (wlen_q == target_q) && (target_q != '0);
        bin_d     = (int'(wlen_q) >= NUM_BINS) ? BW'(NUM_BINS - 1)
                                               : BW'(int'(wlen_q) - 1);
        bin_inc_d = CNT_W'(sat_inc(32'(hist_q[bin_d]), CNT_MAX));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            wlen_q   <= '0;
            wc_q     <= '0;
            bc_q     <= '0;
            for (int k = 0; k < NUM_BINS; k++) hist_q[k] <= '0;
        end else if (abort && busy) begin
            state_q <= ST_IDLE;
        end else if (clr) begin
            state_q  <= ST_SEARCH;
            target_q <= target_len;
            wlen_q   <= '0;
            wc_q     <= '0;
            bc_q     <= '0;
            for (int k = 0; k < NUM_BINS; k++) hist_q[k] <= '0;
        end else if (accept) begin
            bc_q <= bc_d;
            if (state_q == ST_SEARCH) begin
                if (beg_match) state_q <= ST_COUNT;
            end else if (end_match) begin
                state_q <= ST_DONE;
                wlen_q  <= '0;
            end else if (word_ch) begin
                wlen_q <= wlen_d;
            end else if (wlen_q != '0) begin
                if (hit_d) wc_q <= wc_d;
                hist_q[bin_d] <= bin_inc_d;
                wlen_q        <= '0;
            end
        end
    end

    assign word_count = wc_q;
    assign byte_count = bc_q;

    for (genvar k = 0; k < NUM_BINS; k++) begin : g_hist
        assign hist_flat[k*CNT_W +: CNT_W] = hist_q[k];
    end

endmodule

// File: tb/tb_sd_text_word_scanner.sv
// Bench for sd_text_word_scanner: three parameterisations share one stream
// and are checked each cycle against a sliding-window text model.
`timescale 1ns/1ps
module tb_sd_text_word_scanner;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] target_len = 8'd0;
    logic [7:0] in_data = 8'd0;

    always #5 clk = ~clk;

    logic rdy0, busy0, txt0, done0;
    logic [15:0] wc0;
    logic [63:0] h0;
    logic [31:0] bc0;
    logic rdy1, busy1, txt1, done1;
    logic [3:0] wc1;
    logic [15:0] h1;
    logic [31:0] bc1;
    logic rdy2, busy2, txt2, done2;
    logic [15:0] wc2;
    logic [63:0] h2;
    logic [31:0] bc2;

    sd_text_word_scanner dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .target_len(target_len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .busy(busy0), .in_text(txt0), .done(done0),
        .word_count(wc0), .hist_flat(h0), .byte_count(bc0)
    );

    sd_text_word_scanner #(.CNT_W(4)) dut_c4 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .target_len(target_len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .busy(busy1), .in_text(txt1), .done(done1),
        .word_count(wc1), .hist_flat(h1), .byte_count(bc1)
    );

    sd_text_word_scanner #(.ALNUM(1'b1)) dut_an (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .target_len(target_len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy2), .busy(busy2), .in_text(txt2), .done(done2),
        .word_count(wc2), .hist_flat(h2), .byte_count(bc2)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: 0 idle, 1 search, 2 count, 3 done; index a = ALNUM setting.
    localparam logic [71:0] BTAG = {"DLAB_TAG", 8'h0A};
    localparam logic [71:0] ETAG = {"DLAB_END", 8'h0A};
    int m_state, m_tgt, m_bc;
    int m_wlen [2];
    int m_wc [2];
    int m_hist [2][4];
    logic [71:0] win_s, win_c;
    int n_s, n_c;

    function automatic int satv(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit is_wc(input logic [7:0] c, input int a);
        return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z") ||
               c == "_" || (a == 1 && c >= "0" && c <= "9");
    endfunction

    task automatic m_clear();
        m_bc = 0;
        n_s = 0;
        n_c = 0;
        win_s = '0;
        win_c = '0;
        for (int a = 0; a < 2; a++) begin
            m_wlen[a] = 0;
            m_wc[a] = 0;
            for (int k = 0; k < 4; k++) m_hist[a][k] = 0;
        end
    endtask

    task automatic model_step();
        bit mbusy;
        int b;
        mbusy = (m_state == 1 || m_state == 2);
        if (!reset_n) begin
            m_state = 0;
            m_tgt = 0;
            m_clear();
        end else if (abort && mbusy) begin
            m_state = 0;
        end else if (start && !mbusy) begin
            m_clear();
            m_tgt = int'(target_len);
            m_state = 1;
        end else if (in_valid && mbusy) begin
            m_bc++;
            if (m_state == 1) begin
                win_s = {win_s[63:0], in_data};
                n_s++;
                if (n_s >= 9 && win_s == BTAG) m_state = 2;
            end else begin
                win_c = {win_c[63:0], in_data};
                n_c++;
                if (n_c >= 9 && win_c == ETAG) begin
                    m_state = 3;
                    m_wlen[0] = 0;
                    m_wlen[1] = 0;
                end else begin
                    for (int a = 0; a < 2; a++) begin
                        if (is_wc(in_data, a)) begin
                            if (m_wlen[a] < 255) m_wlen[a]++;
                        end else if (m_wlen[a] > 0) begin
                            if (m_tgt != 0 && m_wlen[a] == m_tgt) m_wc[a]++;
                            b = (m_wlen[a] < 4) ? m_wlen[a] : 4;
                            m_hist[a][b-1]++;
                            m_wlen[a] = 0;
                        end
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    function automatic logic [3:0] exp_flags();
        bit bz;
        bz = (m_state == 1 || m_state == 2);
        return {bz, bz, m_state == 2, m_state == 3};
    endfunction

    function automatic logic [127:0] exp16(input int a);
        logic [63:0] h;
        h = '0;
        for (int k = 0; k < 4; k++) h[k*16 +: 16] = 16'(satv(m_hist[a][k], 16));
        return {12'd0, exp_flags(), 32'(m_bc), 16'(satv(m_wc[a], 16)), h};
    endfunction

    function automatic logic [127:0] exp4();
        logic [15:0] h;
        h = '0;
        for (int k = 0; k < 4; k++) h[k*4 +: 4] = 4'(satv(m_hist[0][k], 4));
        return {72'd0, exp_flags(), 32'(m_bc), 4'(satv(m_wc[0], 4)), h};
    endfunction

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("cyc_default", {12'd0, rdy0, busy0, txt0, done0, bc0, wc0, h0}, exp16(0));
            check("cyc_cnt4", {72'd0, rdy1, busy1, txt1, done1, bc1, wc1, h1}, exp4());
            check("cyc_alnum", {12'd0, rdy2, busy2, txt2, done2, bc2, wc2, h2}, exp16(1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data = b;
        waited = 0;
        forever begin
            @(negedge clk);
            if (rdy0) begin
                tick();
                break;
            end
            waited++;
            if (waited > 50) begin
                checks++;
                failures++;
                $display("FAIL handshake_timeout actual=not_ready required=ready");
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input int maxgap);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic pulse_start(input logic [7:0] tgt);
        start = 1'b1;
        target_len = tgt;
        tick();
        start = 1'b0;
        target_len = 8'hAA;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    string t1 = "xyzDLAB_TAG\nthe cat sat on a mat\nDLAB_END\n";
    string s4, s6;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset_state", {rdy0, busy0, txt0, done0, bc0, wc0, h0}, '0);

        tick();
        pulse_start(8'd3);
        send_str(t1, 0);
        @(negedge clk);
        check("t1_word_count", wc0, 4);
        check("t1_hist", h0, 64'h0000_0004_0001_0001);
        check("t1_flags", {done0, txt0, rdy0}, 3'b100);
        check("t1_byte_count", bc0, 42);

        in_valid = 1'b1;
        in_data = " ";
        repeat (3) tick();
        in_valid = 1'b0;
        pulse_abort();
        @(negedge clk);
        check("done_hold", {done0, bc0}, {1'b1, 32'd42});

        tick();
        pulse_start(8'd2);
        send_str("hi DDLAB_TAG\nab\nDLAB_END\n", 0);
        @(negedge clk);
        check("t2_word_count", wc0, 1);
        check("t2_hist", h0, 64'h0000_0000_0001_0000);

        tick();
        pulse_start(8'd3);
        send_str("DLAB_TAG\nthe cat sa", 3);
        pulse_abort();
        @(negedge clk);
        check("t3_abort", {busy0, done0, wc0, bc0}, {2'b00, 16'd2, 32'd19});
        tick();
        in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_frozen", {wc0, bc0, h0}, {16'd2, 32'd19, 64'h0000_0002_0000_0000});
        tick();
        pulse_start(8'd3);
        @(negedge clk);
        check("t3_restart", {busy0, wc0, bc0, h0}, {1'b1, 16'd0, 32'd0, 64'd0});
        tick();
        send_str(t1, 2);
        @(negedge clk);
        check("t3_repeat", {wc0, h0}, {16'd4, 64'h0000_0004_0001_0001});

        s4 = "DLAB_TAG\n";
        for (int i = 0; i < 20; i++) s4 = {s4, "abc "};
        s4 = {s4, "DLAB_END\n"};
        tick();
        pulse_start(8'd3);
        send_str(s4, 0);
        @(negedge clk);
        check("t4_sat_count", wc1, 4'd15);
        check("t4_sat_bin", h1[11:8], 4'd15);
        check("t4_wide_count", wc0, 20);

        tick();
        pulse_start(8'd3);
        send_str("DLAB_TAG\na1b c\nDLAB_END\n", 0);
        @(negedge clk);
        check("t5_alnum0", wc0, 0);
        check("t5_alnum1", wc2, 1);

        tick();
        pulse_start(8'd0);
        send_str("DLAB_TAG\na b\nDLAB_END\n", 0);
        @(negedge clk);
        check("target0", {wc0, h0}, {16'd0, 64'd2});

        tick();
        pulse_start(8'd3);
        send_str("DLAB_TAG\nthe ca", 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("t6_reset", {rdy0, busy0, txt0, done0, bc0, wc0, h0}, '0);

        s6 = "DLAB_TAG\n";
        for (int i = 0; i < 501; i++) s6 = {s6, " "};
        s6 = {s6, "the cat sat on a mat\nDLAB_END\n"};
        tick();
        pulse_start(8'd3);
        send_str(s6.substr(0, 511), 0);
        repeat (30) tick();
        send_str(s6.substr(512, s6.len() - 1), 0);
        @(negedge clk);
        check("t6_split", {done0, wc0, bc0}, {1'b1, 16'd4, 32'd540});

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
